// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer
//  Description : Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT)
//                with memory handshake, wait timeout and retired counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src_b,
    output logic [5:0]       alu_op,
    output logic             halted,
    output logic             timeout,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] c_S_FETCH  = 3'd0;
    localparam logic [2:0] c_S_DECODE = 3'd1;
    localparam logic [2:0] c_S_EXEC   = 3'd2;
    localparam logic [2:0] c_S_MEM    = 3'd3;
    localparam logic [2:0] c_S_WB     = 3'd4;
    localparam logic [2:0] c_S_HALT   = 3'd5;

    localparam logic [3:0] c_I_ADD  = 4'd0;
    localparam logic [3:0] c_I_SUB  = 4'd1;
    localparam logic [3:0] c_I_SLT  = 4'd2;
    localparam logic [3:0] c_I_JR   = 4'd3;
    localparam logic [3:0] c_I_SYS  = 4'd4;
    localparam logic [3:0] c_I_NOOP = 4'd5;
    localparam logic [3:0] c_I_LW   = 4'd6;
    localparam logic [3:0] c_I_SW   = 4'd7;
    localparam logic [3:0] c_I_J    = 4'd8;
    localparam logic [3:0] c_I_JAL  = 4'd9;
    localparam logic [3:0] c_I_BNE  = 4'd10;
    localparam logic [3:0] c_I_XORI = 4'd11;
    localparam logic [3:0] c_I_ILL  = 4'd12;

    localparam logic [5:0] c_ALU_ADD  = 6'b100000;
    localparam logic [5:0] c_ALU_SUB  = 6'b100010;
    localparam logic [5:0] c_ALU_SLT  = 6'b101010;
    localparam logic [5:0] c_ALU_XOR  = 6'b100110;
    localparam logic [5:0] c_ALU_PASS = 6'b101100;

    localparam int               c_WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [c_WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]    r_retired;
    logic                r_timeout;
    logic                r_illegal;
    logic [3:0]          w_cls;
    logic                w_retire;
    logic                w_set_timeout;
    logic                w_set_illegal;
    logic                w_wait_inc;
    logic                w_is_rtype;

    // Instruction class from the IR fields
    always_comb begin
        w_cls = c_I_ILL;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: w_cls = c_I_ADD;
                    6'b100010: w_cls = c_I_SUB;
                    6'b101010: w_cls = c_I_SLT;
                    6'b001000: w_cls = c_I_JR;
                    6'b001100: w_cls = c_I_SYS;
                    6'b000000: w_cls = c_I_NOOP;
                    default:   w_cls = c_I_ILL;
                endcase
            end
            6'b100011: w_cls = c_I_LW;
            6'b101011: w_cls = c_I_SW;
            6'b000010: w_cls = c_I_J;
            6'b000011: w_cls = c_I_JAL;
            6'b000101: w_cls = c_I_BNE;
            6'b001110: w_cls = c_I_XORI;
            default:   w_cls = c_I_ILL;
        endcase
    end

    assign w_is_rtype = (w_cls == c_I_ADD) || (w_cls == c_I_SUB) || (w_cls == c_I_SLT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_S_FETCH;
            r_wait    <= '0;
            r_retired <= '0;
            r_timeout <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_wait_inc)
                r_wait <= r_wait + c_WAIT_W'(1);
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
            if (w_set_timeout)
                r_timeout <= 1'b1;
            if (w_set_illegal)
                r_illegal <= 1'b1;
        end
    end

    // mem_ready wins over the wait limit when both land on the same cycle
    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_set_timeout = 1'b0;
        w_set_illegal = 1'b0;
        w_wait_inc    = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                if (mem_ready) begin
                    w_next = c_S_DECODE;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_next        = c_S_HALT;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            c_S_DECODE: begin
                if (w_cls == c_I_SYS) begin
                    w_next   = c_S_HALT;
                    w_retire = 1'b1;
                end else begin
                    w_next = c_S_EXEC;
                end
            end
            c_S_EXEC: begin
                if (w_is_rtype || (w_cls == c_I_XORI)) begin
                    w_next = c_S_WB;
                end else if ((w_cls == c_I_LW) || (w_cls == c_I_SW)) begin
                    w_next = c_S_MEM;
                end else begin
                    w_next        = c_S_FETCH;
                    w_retire      = 1'b1;
                    w_set_illegal = (w_cls == c_I_ILL);
                end
            end
            c_S_MEM: begin
                if (mem_ready) begin
                    if (w_cls == c_I_SW) begin
                        w_next   = c_S_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = c_S_WB;
                    end
                end else if (r_wait == c_WAIT_LAST) begin
                    w_next        = c_S_HALT;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            c_S_WB: begin
                w_next   = c_S_FETCH;
                w_retire = 1'b1;
            end
            c_S_HALT: w_next = c_S_HALT;
            default:  w_next = c_S_FETCH;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        reg_write = 1'b0;
        reg_dst   = 2'd0;
        wb_sel    = 2'd0;
        alu_src_b = 1'b0;
        alu_op    = c_ALU_PASS;
        halted    = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            c_S_EXEC: begin
                case (w_cls)
                    c_I_ADD: alu_op = c_ALU_ADD;
                    c_I_SUB: alu_op = c_ALU_SUB;
                    c_I_SLT: alu_op = c_ALU_SLT;
                    c_I_XORI: begin
                        alu_op    = c_ALU_XOR;
                        alu_src_b = 1'b1;
                    end
                    c_I_LW, c_I_SW: begin
                        alu_op    = c_ALU_ADD;
                        alu_src_b = 1'b1;
                    end
                    c_I_BNE: begin
                        alu_op = c_ALU_SUB;
                        if (!zero) begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                        end
                    end
                    c_I_J: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                    end
                    c_I_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                        reg_write = 1'b1;
                        reg_dst   = 2'd2;
                        wb_sel    = 2'd2;
                    end
                    c_I_JR: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd3;
                    end
                    default: ;
                endcase
            end
            c_S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (w_cls == c_I_SW);
            end
            c_S_WB: begin
                reg_write = 1'b1;
                reg_dst   = w_is_rtype ? 2'd1 : 2'd0;
                wb_sel    = (w_cls == c_I_LW) ? 2'd1 : 2'd0;
            end
            c_S_HALT: halted = 1'b1;
            default: ;
        endcase
        // Outputs are forced low for as long as reset is held
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'd0;
            reg_write = 1'b0;
            reg_dst   = 2'd0;
            wb_sel    = 2'd0;
            alu_src_b = 1'b0;
            alu_op    = 6'd0;
            halted    = 1'b0;
        end
    end

    assign timeout = r_timeout;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_sequencer
//  Description : Directed self-checking bench for multicycle_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_sel;
    logic        alu_src_b;
    logic [5:0]  alu_op;
    logic        halted;
    logic        timeout;
    logic        illegal;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .halted(halted),
        .timeout(timeout), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction through FETCH (zero-wait) and DECODE; returns in cycle 3
    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = 1'b1;
        #1;
        chk("fetch_req", {31'd0, mem_req}, 32'd1);
        chk("fetch_ir",  {30'd0, ir_write, pc_write}, 32'd3);
        tick;
        chk("decode_quiet", {29'd0, mem_req, pc_write, reg_write}, 32'd0);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        tick;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_alu", {26'd0, alu_op}, 32'd0);
        chk("rst_ret", retired, 32'd0);
        chk("rst_flags", {29'd0, halted, timeout, illegal}, 32'd0);
        tick;
        reset = 1'b0;

        // ADD
        fetch_decode(6'b000000, 6'b100000, 1'b0);
        chk("add_alu", {26'd0, alu_op}, 32'h20);
        chk("add_srcb", {31'd0, alu_src_b}, 32'd0);
        tick;
        chk("add_wb", {27'd0, reg_write, reg_dst, wb_sel}, {27'd0, 1'b1, 2'd1, 2'd0});
        tick; exp_ret++;
        chk("add_ret", retired, exp_ret);

        // LW with three wait cycles in MEM
        fetch_decode(6'b100011, 6'b000000, 1'b0);
        chk("lw_exec", {25'd0, alu_op, alu_src_b}, {25'd0, 6'b100000, 1'b1});
        mem_ready = 1'b0;
        tick;
        chk("lw_mem", {30'd0, mem_req, mem_we}, 32'd2);
        tick; tick; tick;
        chk("lw_mem_wait", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        #1;
        chk("lw_no_rw_yet", {31'd0, reg_write}, 32'd0);
        tick;
        chk("lw_wb", {27'd0, reg_write, reg_dst, wb_sel}, {27'd0, 1'b1, 2'd0, 2'd1});
        tick; exp_ret++;
        chk("lw_ret", retired, exp_ret);

        // SW zero-wait
        fetch_decode(6'b101011, 6'b000000, 1'b0);
        tick;
        chk("sw_mem", {30'd0, mem_req, mem_we}, 32'd3);
        tick; exp_ret++;
        chk("sw_ret", retired, exp_ret);
        chk("sw_fetch_we", {31'd0, mem_we}, 32'd0);

        // BNE taken / not taken
        fetch_decode(6'b000101, 6'b000000, 1'b1);
        chk("bne_z1", {25'd0, alu_op, pc_write}, {25'd0, 6'b100010, 1'b0});
        tick; exp_ret++;
        chk("bne_z1_ret", retired, exp_ret);
        fetch_decode(6'b000101, 6'b000000, 1'b0);
        chk("bne_z0", {29'd0, pc_write, pc_src}, {29'd0, 1'b1, 2'd1});
        tick; exp_ret++;
        chk("bne_z0_ret", retired, exp_ret);

        // JAL
        fetch_decode(6'b000011, 6'b000000, 1'b0);
        chk("jal_exec", {24'd0, pc_write, pc_src, reg_write, reg_dst, wb_sel},
            {24'd0, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2});
        tick; exp_ret++;
        chk("jal_ret", retired, exp_ret);

        // XORI
        fetch_decode(6'b001110, 6'b000000, 1'b0);
        chk("xori_exec", {25'd0, alu_op, alu_src_b}, {25'd0, 6'b100110, 1'b1});
        tick;
        chk("xori_wb", {27'd0, reg_write, reg_dst, wb_sel}, {27'd0, 1'b1, 2'd0, 2'd0});
        tick; exp_ret++;

        // JR
        fetch_decode(6'b000000, 6'b001000, 1'b0);
        chk("jr_exec", {29'd0, pc_write, pc_src}, {29'd0, 1'b1, 2'd3});
        chk("jr_alu", {26'd0, alu_op}, 32'h2c);
        tick; exp_ret++;
        chk("jr_ret", retired, exp_ret);

        // Unknown opcode
        fetch_decode(6'b111111, 6'b000000, 1'b0);
        chk("ill_exec", {29'd0, pc_write, reg_write, illegal}, 32'd0);
        tick; exp_ret++;
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_ret", retired, exp_ret);

        // SYSCALL halts after DECODE
        fetch_decode(6'b000000, 6'b001100, 1'b0);
        exp_ret++;
        chk("sys_halt", {30'd0, halted, mem_req}, 32'd2);
        chk("sys_ret", retired, exp_ret);
        tick; tick;
        chk("sys_sticky", {30'd0, halted, mem_req}, 32'd2);
        chk("sys_no_to", {31'd0, timeout}, 32'd0);

        // Reset asserted mid-MEM
        reset = 1'b1; tick; reset = 1'b0;
        fetch_decode(6'b100011, 6'b000000, 1'b0);
        mem_ready = 1'b0;
        tick;
        chk("midmem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midmem_rst_out", {30'd0, mem_req, reg_write}, 32'd0);
        chk("midmem_rst_ret", retired, 32'd0);
        tick;
        reset = 1'b0;
        #1;
        chk("midmem_fetch", {30'd0, mem_req, mem_we}, 32'd2);
        chk("midmem_flags", {29'd0, halted, timeout, illegal}, 32'd0);

        // Fetch never acknowledged: halt after 15 wait cycles
        for (int i = 0; i < 14; i++) tick;
        chk("to_edge", {30'd0, halted, mem_req}, 32'd1);
        tick;
        chk("to_halt", {29'd0, halted, timeout, mem_req}, 32'd6);
        chk("to_ret", retired, 32'd0);

        // mem_ready on the limit cycle completes the access
        reset = 1'b1; tick; reset = 1'b0;
        opcode = 6'b000000; funct = 6'b000000;
        for (int i = 0; i < 14; i++) tick;
        mem_ready = 1'b1;
        #1;
        chk("edge_ir", {31'd0, ir_write}, 32'd1);
        tick;
        chk("edge_no_to", {30'd0, halted, timeout}, 32'd0);
        tick; tick;
        chk("edge_noop_ret", retired, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
